// File: rtl/uart_rx_ascii.sv
// uart_rx_ascii: 8N1 UART receiver producing one byte per valid frame.
// The rx line is synchronised, and then a mid-bit sampling FSM rebuilds each
// byte LSB-first. Good frames pulse char_valid. A low stop bit pulses
// frame_error and parks the receiver in BREAK until the line returns high.
module uart_rx_ascii #(
  parameter int UART_RX_BAUD = 20,
  parameter int freq         = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] ascii_char,
  output logic       char_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int DIV  = freq / UART_RX_BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;

  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    char_q, char_d;
  logic          cv_q, cv_d;
  logic          fe_q, fe_d;
  logic          busy_q, busy_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  // fill counts the clocks needed to flush the preset synchroniser after
  // reset; armed is set only once a genuine high level has been seen, so a
  // line that is already low at reset release never looks like a start bit.
  logic [1:0]    fill_q, fill_d;
  logic          armed_q, armed_d;
  logic          rx_s;

  assign rx_s        = sync2_q;
  assign ascii_char  = char_q;
  assign char_valid  = cv_q;
  assign frame_error = fe_q;
  assign busy        = busy_q;

  // Next-state logic: synchroniser, arming, and the bit-sampling FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    char_d  = char_q;
    cv_d    = 1'b0;
    fe_d    = 1'b0;
    sync1_d = rx;
    sync2_d = sync1_q;

    if (fill_q == 2'd2) begin
      fill_d = fill_q;
    end else begin
      fill_d = fill_q + 2'd1;
    end

    if ((fill_q == 2'd2) && rx_s) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (armed_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            char_d  = shreg_q;
            cv_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = 3'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; the synchroniser presets to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      char_q  <= 8'h00;
      cv_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      char_q  <= char_d;
      cv_q    <= cv_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: doc/uart_rx_ascii.md
Name: uart_rx_ascii

Overview:
- Serial 8N1 UART receiver that feeds the sequence checker's character input.
- Oversamples the asynchronous rx line with the system clock and reassembles bytes LSB-first.
- Presents each byte on ascii_char with a one-cycle char_valid strobe, so it connects directly to the checker's ascii_char/char_valid pair.
- Flags malformed frames on a separate strobe and recovers cleanly from line breaks.

Parameters:
- UART_RX_BAUD, 20, line bit rate in bits/s.
- freq, 200, clk frequency in Hz.
- DIV (localparam) = freq/UART_RX_BAUD, integer clocks per bit. DIV >= 4 is required; HALF = DIV/2, integer division.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial line. Idle high, asynchronous to clk.
- ascii_char  output  8  last correctly framed byte. Held until the next good frame.
- char_valid  output  1  one-cycle pulse: ascii_char is new this cycle.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - ascii_char=0, char_valid=0, frame_error=0, busy=0.
  - Counters and shift register cleared.
  - Both synchronizer flops preset to 1, so no false start follows reset release.
- rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s, which lags rx by 2 clocks.
- A single bit counter cnt (width clog2(DIV)+1) and a bit index idx (0..7) drive the FSM.
- IDLE:
  - rx_s==0 goes to START with cnt=0. Call this edge T0.
- START:
  - At cnt==HALF-1, sample rx_s.
  - rx_s==1 is a glitch: return to IDLE with no output.
  - rx_s==0 goes to DATA with cnt=0, idx=0.
- DATA:
  - At cnt==DIV-1, sample rx_s into the shift register MSB and shift right, so the LSB arrives first.
  - After idx==7 is sampled, go to STOP.
- STOP:
  - At cnt==DIV-1, sample rx_s.
  - rx_s==1: ascii_char <= shift register, char_valid=1 for exactly one cycle, go to IDLE.
  - rx_s==0: frame_error=1 for one cycle, ascii_char unchanged, go to BREAK.
- BREAK:
  - Stay until rx_s==1, then go to IDLE.
  - A line held low never causes repeated frames or repeated error pulses.
- Sampling points from T0 are HALF+k*DIV for k=0 (start), k=1..8 (data) and k=9 (stop).
- Latency:
  - char_valid is high in cycle T0+HALF+9*DIV+1.
  - With defaults (DIV=10) that is 96 clocks after T0, or 98 clocks after the rx pin falling edge.
- Return to IDLE happens mid stop bit, so a start bit following immediately after one stop bit is caught. Back-to-back frames must have zero loss.
- char_valid and frame_error are never high in the same cycle.
- Byte values 0x00 and 0xFF are ordinary data. 0x00 is used as framing by the downstream checker and must be delivered.
- Reset asserted mid-frame:
  - Frame is discarded and no strobes are produced.
  - After release, the receiver waits for a fresh falling edge. A line already low at release is not a start bit, because the synchronizer was preset to 1 and IDLE needs a 1→0 on rx_s.

Test Plan:
- Send one frame 0x41 ('A') at DIV=10 → ascii_char=0x41, char_valid high for exactly 1 cycle, 98 clocks after rx falls. frame_error stays 0. busy falls the same cycle.
- Send "1A2B3C4D" back-to-back, single stop bit each → 8 char_valid pulses in order 0x31,0x41,0x32,0x42,0x33,0x43,0x34,0x44, spaced 100 clocks apart, no errors.
- Pulse rx low for 3 clocks, then high → START rejects it as a glitch. No char_valid, no frame_error, busy high for 5 cycles then 0.
- Frame 0x55 with stop bit 0, line held low 40 clocks, then high, then frame 0x31 → one frame_error pulse only and ascii_char keeps its previous value. Next char_valid carries 0x31.
- Frames 0x00 then 0xFF → ascii_char 0x00, then 0xFF, each with a single char_valid.
- Assert rst during data bit 4 of frame 0x5A, release 5 clocks later while rx is low → outputs 0 during reset and no strobes for the broken frame. The next full frame 0x42 is received correctly.
